// File: rtl/nmea_uart_rx_if.sv
// Receiver-side bundle: serial line in, character strobes out toward the NMEA pattern search stage.
interface nmea_uart_rx_if #(
  parameter int N_BITS = 8
);
  logic              uart_rx;
  logic [N_BITS-1:0] char_out;
  logic              char_valid;
  logic              frame_err;
  logic              busy;

  modport master (
    input  uart_rx,
    output char_out,
    output char_valid,
    output frame_err,
    output busy
  );

  modport slave (
    output uart_rx,
    input  char_out,
    input  char_valid,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/nmea_uart_rx.sv
// 8N1-style UART receiver: 2-flop synchroniser, mid-bit sampling, framing-error and break handling.
module nmea_uart_rx #(
  parameter int N_BITS    = 8,
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic            clk,
  input  logic            rst,
  nmea_uart_rx_if.master  bus
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;
  localparam int BIT_W        = $clog2(N_BITS + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(N_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t            state_reg, state_next;
  logic [1:0]        sync_reg;
  logic [CNT_W-1:0]  clk_cnt_reg, clk_cnt_next;
  logic [BIT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic [N_BITS-1:0] shift_reg, shift_next;
  logic [N_BITS-1:0] char_out_reg, char_out_next;
  logic              char_valid_reg, char_valid_next;
  logic              frame_err_reg, frame_err_next;
  logic              rx_s;

  // Synchroniser flops reset to the idle-high line level.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) sync_reg[gi] <= 1'b1;
          else      sync_reg[gi] <= bus.uart_rx;
        end
      end else begin : g_rest
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) sync_reg[gi] <= 1'b1;
          else      sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign rx_s = sync_reg[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= S_IDLE;
      clk_cnt_reg    <= '0;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      char_out_reg   <= '0;
      char_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      clk_cnt_reg    <= clk_cnt_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      char_out_reg   <= char_out_next;
      char_valid_reg <= char_valid_next;
      frame_err_reg  <= frame_err_next;
    end
  end

  // The clock counter is zeroed on every state change, so it never has to wrap.
  always_comb begin
    state_next      = state_reg;
    clk_cnt_next    = clk_cnt_reg + 1'b1;
    bit_cnt_next    = bit_cnt_reg;
    shift_next      = shift_reg;
    char_out_next   = char_out_reg;
    char_valid_next = 1'b0;
    frame_err_next  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        clk_cnt_next = '0;
        if (!rx_s) state_next = S_START;
      end
      S_START: begin
        if (clk_cnt_reg == HALF_LAST) begin
          clk_cnt_next = '0;
          bit_cnt_next = '0;
          state_next   = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (clk_cnt_reg == FULL_LAST) begin
          clk_cnt_next = '0;
          shift_next   = {rx_s, shift_reg[N_BITS-1:1]};
          if (bit_cnt_reg == BIT_LAST) begin
            bit_cnt_next = '0;
            state_next   = S_STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (clk_cnt_reg == FULL_LAST) begin
          clk_cnt_next = '0;
          if (rx_s) begin
            char_out_next   = shift_reg;
            char_valid_next = 1'b1;
            state_next      = S_IDLE;
          end else begin
            frame_err_next = 1'b1;
            state_next     = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        clk_cnt_next = '0;
        if (rx_s) state_next = S_IDLE;
      end
      default: begin
        clk_cnt_next = '0;
        state_next   = S_IDLE;
      end
    endcase
  end

  assign bus.char_out   = char_out_reg;
  assign bus.char_valid = char_valid_reg;
  assign bus.frame_err  = frame_err_reg;
  assign bus.busy       = (state_reg != S_IDLE);
endmodule

// File: tb/tb_nmea_uart_rx.sv
// Randomised bench for nmea_uart_rx with a frame-level reference model.
module tb_nmea_uart_rx;
  localparam int N_BITS    = 8;
  localparam int CLK_FREQ  = 1600;
  localparam int BAUD_RATE = 100;
  localparam int CPB       = CLK_FREQ / BAUD_RATE;
  localparam int LAT       = 2 + CPB / 2 + (N_BITS + 1) * CPB + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  nmea_uart_rx_if #(.N_BITS(N_BITS)) bus ();

  nmea_uart_rx #(
    .N_BITS(N_BITS),
    .CLK_FREQ(CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Observed strobes
  logic [7:0]  got_b[$];
  int unsigned got_t[$];
  int          fe_seen = 0;
  int          both_seen = 0;

  always @(negedge clk) begin
    if (bus.char_valid) begin
      got_b.push_back(bus.char_out);
      got_t.push_back(cyc);
    end
    if (bus.frame_err) fe_seen++;
    if (bus.char_valid && bus.frame_err) both_seen++;
  end

  // Reference model: one expected byte (with its due cycle) per well-framed frame, one error per bad stop.
  logic [7:0]  exp_b[$];
  int unsigned exp_t[$];
  int          exp_fe = 0;
  logic [7:0]  last_good = 8'h00;

  task automatic clear_all();
    got_b.delete(); got_t.delete(); exp_b.delete(); exp_t.delete();
    fe_seen = 0; both_seen = 0; exp_fe = 0;
  endtask

  task automatic hold(input logic v, input int n);
    bus.uart_rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    int unsigned t0;
    t0 = cyc;
    hold(1'b0, CPB);
    for (int i = 0; i < N_BITS; i++) hold(b[i], CPB);
    hold(stop_ok, CPB);
    if (stop_ok) begin
      exp_b.push_back(b);
      exp_t.push_back(t0 + LAT);
      last_good = b;
    end else begin
      exp_fe++;
    end
  endtask

  task automatic test_reset();
    bus.uart_rx = 1'b1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.char_out !== 8'h00) begin failures++; $display("FAIL reset_char_out: got %0h expected 0", bus.char_out); end
    checks++; if (bus.char_valid !== 1'b0) begin failures++; $display("FAIL reset_char_valid: got %b expected 0", bus.char_valid); end
    checks++; if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err: got %b expected 0", bus.frame_err); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    rst = 1'b1;
    hold(1'b1, 20);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_single();
    clear_all();
    send_frame(8'h24, 1'b1);
    hold(1'b1, 40);
    checks++; if (got_b.size() !== 1) begin failures++; $display("FAIL single_count: got %0d expected 1", got_b.size()); end
    if (got_b.size() == 1) begin
      checks++; if (got_b[0] !== 8'h24) begin failures++; $display("FAIL single_value: got %0h expected 24", got_b[0]); end
      checks++;
      if (got_t[0] + 1 < exp_t[0] || got_t[0] > exp_t[0] + 1) begin
        failures++; $display("FAIL single_latency: got cycle %0d expected %0d+-1", got_t[0], exp_t[0]);
      end
    end
    checks++; if (fe_seen !== 0) begin failures++; $display("FAIL single_frame_err: got %0d expected 0", fe_seen); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL single_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] msg [10];
    msg[0] = 8'h47; msg[1] = 8'h50; msg[2] = 8'h47; msg[3] = 8'h47; msg[4] = 8'h41;
    for (int i = 5; i < 10; i++) msg[i] = 8'($urandom);
    clear_all();
    for (int i = 0; i < 10; i++) send_frame(msg[i], 1'b1);
    hold(1'b1, 40);
    checks++; if (got_b.size() !== exp_b.size()) begin failures++; $display("FAIL b2b_count: got %0d expected %0d", got_b.size(), exp_b.size()); end
    for (int i = 0; i < got_b.size() && i < exp_b.size(); i++) begin
      checks++; if (got_b[i] !== exp_b[i]) begin failures++; $display("FAIL b2b_value[%0d]: got %0h expected %0h", i, got_b[i], exp_b[i]); end
      if (i > 0) begin
        checks++;
        if (got_t[i] - got_t[i-1] < 159 || got_t[i] - got_t[i-1] > 161) begin
          failures++; $display("FAIL b2b_spacing[%0d]: got %0d expected 160+-1", i, got_t[i] - got_t[i-1]);
        end
      end
    end
    checks++; if (fe_seen !== 0) begin failures++; $display("FAIL b2b_frame_err: got %0d expected 0", fe_seen); end
  endtask

  task automatic test_glitch();
    int k;
    clear_all();
    hold(1'b0, 4);
    bus.uart_rx = 1'b1;
    k = 0;
    while (bus.busy && k < 30) begin
      @(posedge clk); #1; k++;
    end
    checks++; if (k > 12) begin failures++; $display("FAIL glitch_busy_release: got %0d cycles expected <=12", k); end
    hold(1'b1, 200);
    checks++; if (got_b.size() !== 0) begin failures++; $display("FAIL glitch_strobe: got %0d expected 0", got_b.size()); end
    checks++; if (fe_seen !== 0) begin failures++; $display("FAIL glitch_frame_err: got %0d expected 0", fe_seen); end
  endtask

  task automatic test_break();
    logic [7:0] prev;
    clear_all();
    prev = last_good;
    send_frame(8'h55, 1'b0);
    hold(1'b0, 48);
    checks++; if (fe_seen !== exp_fe) begin failures++; $display("FAIL break_frame_err: got %0d expected %0d", fe_seen, exp_fe); end
    checks++; if (bus.char_out !== prev) begin failures++; $display("FAIL break_char_hold: got %0h expected %0h", bus.char_out, prev); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL break_busy_low_line: got %b expected 1", bus.busy); end
    hold(1'b1, 32);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL break_busy_idle: got %b expected 0", bus.busy); end
    send_frame(8'h41, 1'b1);
    hold(1'b1, 40);
    checks++; if (got_b.size() !== 1) begin failures++; $display("FAIL break_count: got %0d expected 1", got_b.size()); end
    if (got_b.size() == 1) begin
      checks++; if (got_b[0] !== 8'h41) begin failures++; $display("FAIL break_next_value: got %0h expected 41", got_b[0]); end
    end
    checks++; if (fe_seen !== 1) begin failures++; $display("FAIL break_single_err: got %0d expected 1", fe_seen); end
    checks++; if (both_seen !== 0) begin failures++; $display("FAIL break_overlap: got %0d expected 0", both_seen); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    clear_all();
    b = 8'h47;
    hold(1'b0, CPB);
    for (int i = 0; i < 3; i++) hold(b[i], CPB);
    hold(b[3], CPB / 2);
    #3 rst = 1'b0;
    bus.uart_rx = 1'b1;
    #1;
    checks++; if (bus.char_out !== 8'h00) begin failures++; $display("FAIL midrst_char_out: got %0h expected 0", bus.char_out); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    last_good = 8'h00;
    hold(1'b1, 32);
    send_frame(8'h0D, 1'b1);
    hold(1'b1, 40);
    checks++; if (got_b.size() !== 1) begin failures++; $display("FAIL midrst_count: got %0d expected 1", got_b.size()); end
    if (got_b.size() == 1) begin
      checks++; if (got_b[0] !== 8'h0D) begin failures++; $display("FAIL midrst_value: got %0h expected 0d", got_b[0]); end
    end
    checks++; if (fe_seen !== 0) begin failures++; $display("FAIL midrst_frame_err: got %0d expected 0", fe_seen); end
  endtask

  task automatic test_held_low();
    int low_busy;
    int k;
    clear_all();
    rst = 1'b0;
    bus.uart_rx = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    low_busy = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (i >= 4 && !bus.busy) low_busy++;
    end
    checks++; if (low_busy !== 0) begin failures++; $display("FAIL held_busy: got %0d idle cycles expected 0", low_busy); end
    checks++; if (fe_seen !== 1) begin failures++; $display("FAIL held_frame_err: got %0d expected 1", fe_seen); end
    checks++; if (got_b.size() !== 0) begin failures++; $display("FAIL held_strobe: got %0d expected 0", got_b.size()); end
    bus.uart_rx = 1'b1;
    k = 0;
    while (bus.busy && k < 20) begin
      @(posedge clk); #1; k++;
    end
    checks++; if (k > 5) begin failures++; $display("FAIL held_release: got %0d cycles expected <=5", k); end
    last_good = bus.char_out;
    hold(1'b1, 20);
  endtask

  task automatic test_random();
    logic       good;
    logic [7:0] b;
    int         gap;
    clear_all();
    for (int n = 0; n < 14; n++) begin
      b    = 8'($urandom);
      good = ($urandom_range(0, 3) != 0);
      send_frame(b, good);
      gap  = good ? int'($urandom_range(0, 24)) : int'($urandom_range(CPB, 40));
      if (gap > 0) hold(1'b1, gap);
    end
    hold(1'b1, 40);
    checks++; if (got_b.size() !== exp_b.size()) begin failures++; $display("FAIL rand_count: got %0d expected %0d", got_b.size(), exp_b.size()); end
    for (int i = 0; i < got_b.size() && i < exp_b.size(); i++) begin
      checks++; if (got_b[i] !== exp_b[i]) begin failures++; $display("FAIL rand_value[%0d]: got %0h expected %0h", i, got_b[i], exp_b[i]); end
      checks++;
      if (got_t[i] + 1 < exp_t[i] || got_t[i] > exp_t[i] + 1) begin
        failures++; $display("FAIL rand_latency[%0d]: got cycle %0d expected %0d+-1", i, got_t[i], exp_t[i]);
      end
    end
    checks++; if (fe_seen !== exp_fe) begin failures++; $display("FAIL rand_frame_err: got %0d expected %0d", fe_seen, exp_fe); end
    checks++; if (both_seen !== 0) begin failures++; $display("FAIL rand_overlap: got %0d expected 0", both_seen); end
    checks++; if (bus.char_out !== last_good) begin failures++; $display("FAIL rand_char_hold: got %0h expected %0h", bus.char_out, last_good); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_break();
    test_reset_mid();
    test_held_low();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/nmea_uart_rx.md
Name: nmea_uart_rx

Overview:
- UART receiver that turns the GPS module's serial NMEA stream into byte strobes.
- Sits directly upstream of the NMEA pattern search stage; its char_out/char_valid drive that stage's character inputs.
- Format is 8N1 by default: one start bit, N_BITS data bits LSB first, one stop bit, no parity.
- Uses a 2-flop synchroniser, mid-bit sampling, framing-error detection and break handling.

Parameters:
- N_BITS, 8, data bits per frame.
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD_RATE, 9600, serial bit rate.
- CLKS_PER_BIT (derived localparam), CLK_FREQ/BAUD_RATE (integer division), clocks per bit. Must be >= 4.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  reset, asynchronous, active-low. rst=0 resets immediately; release is synchronous to clk.
- uart_rx  input  1  asynchronous serial line, idle high.
- char_out  output  N_BITS  last correctly framed byte.
- char_valid  output  1  one-cycle strobe; char_out is valid in that cycle.
- frame_err  output  1  one-cycle strobe; stop bit was sampled low.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values:
  - char_out=0, char_valid=0, frame_err=0, busy=0.
  - Both synchroniser flops=1, FSM=IDLE, bit counter=0, clock counter=0, shift register=0.
- Synchroniser: rx_s is uart_rx delayed by two flops. All decisions use rx_s only.
- Clock counter: width $clog2(CLKS_PER_BIT)+1; cleared on every state entry.
- States:
  - IDLE: if rx_s==0, go to START.
  - START: count to CLKS_PER_BIT/2-1, then sample rx_s.
    - 0: go to DATA.
    - 1 (glitch): go to IDLE with no output.
  - DATA: every CLKS_PER_BIT clocks, sample rx_s into shift register MSB and shift right, so the first bit received ends in bit 0.
    - After N_BITS samples, go to STOP.
  - STOP: after CLKS_PER_BIT clocks, sample rx_s.
    - 1: char_out<=shift register, char_valid=1 for exactly the next cycle, go to IDLE.
    - 0: frame_err=1 for exactly one cycle, char_out unchanged, go to BREAK.
  - BREAK: wait until rx_s==1, then go to IDLE.
    - A held-low line produces exactly one frame_err and no spurious frames.
- Latency: char_valid rises 2 + CLKS_PER_BIT/2 + (N_BITS+1)*CLKS_PER_BIT + 1 cycles (±1) after the uart_rx falling edge of the start bit.
- Back-to-back frames:
  - The FSM is back in IDLE half a bit into the stop bit.
  - A start edge immediately after the stop bit must be caught, so zero idle time between frames is supported.
- char_valid and frame_err are never high in the same cycle.
- No backpressure. The consumer must accept every strobe; char_out holds until the next valid frame.
- Reset mid-frame: immediate return to reset values. The frame in progress is discarded. If the line is low at reset release, the remainder of that frame is treated as a start bit.
  - The resulting garbage must end in either a frame_err or a valid strobe; there must be no lockup.
- Counter wrap: counters never wrap. They are cleared on state change, and CLKS_PER_BIT-1 must fit in the counter width.

Test Plan (CLK_FREQ=1600, BAUD_RATE=100, so CLKS_PER_BIT=16):
- Send 0x24 ('$') 8N1 with idle before and after -> one char_valid, char_out=0x24, frame_err never high, busy low after stop.
- Send "GPGGA" (0x47 0x50 0x47 0x47 0x41) with zero idle between frames:
  - Expect five char_valid strobes, in order, with those values.
  - Strobes are spaced 160±1 cycles apart.
- Pulse uart_rx low for 4 cycles, then hold high for 200 cycles -> no char_valid, no frame_err, busy returns to 0 within 12 cycles of the pulse end.
- Send 0x55 with stop bit 0, hold the line low 48 more cycles, then high 32 cycles, then send 0x41:
  - Expect exactly one frame_err and no char_valid for 0x55.
  - Then char_valid with char_out=0x41.
- Assert rst=0 for 3 cycles in the middle of the DATA bits of 0x47:
  - Outputs go 0 asynchronously.
  - After rst=1 and the line idles 32 cycles, sending 0x0D yields char_valid with char_out=0x0D.
- Drive uart_rx=0 during reset and for 300 cycles after release:
  - Expect exactly one frame_err.
  - busy stays high until the line returns high, then IDLE.
